// File: rtl/timer_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// timer_ctrl_fsm
//   Countdown timer controller. Extends the original start/stop/reset
//   state machine with:
//     - a loadable WIDTH-bit down-counter,
//     - a programmable prescaler,
//     - PAUSE and EXPIRED states,
//     - optional auto-reload,
//     - a one-cycle expiry pulse.
//
// Parameters
//   WIDTH       width of load_val / count
//   PRESCALE_W  width of the prescaler counter and of prescale
//
// Ports
//   c             clock, rising edge
//   r             asynchronous active-high reset
//   e             start / resume request (level)
//   s             stop request (level), highest priority after reset
//   p             pause request (level)
//   reload_en     1 = reload load_val on expiry, 0 = one-shot
//   load_val      start value, sampled whenever a count is (re)loaded
//   prescale      clock edges per decrement minus 1, sampled continuously
//   count         registered counter value
//   currentState  00 IDLE, 01 RUN, 10 PAUSE, 11 EXPIRED
//   expired       registered one-cycle pulse on expiry
//   busy          high in RUN or PAUSE (decode of state)
// -----------------------------------------------------------------------------
module timer_ctrl_fsm #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
) (
  input  logic                  c,
  input  logic                  r,
  input  logic                  e,
  input  logic                  s,
  input  logic                  p,
  input  logic                  reload_en,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic [1:0]            currentState,
  output logic                  expired,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    PAUSE   = 2'b10,
    EXPIRED = 2'b11
  } state_t;

  state_t                state, state_nx;
  logic [WIDTH-1:0]      count_nx;
  logic [PRESCALE_W-1:0] presc, presc_nx;
  logic                  expired_nx;
  logic                  tick;
  logic                  terminal;

  // Decrement that can never wrap below zero.
  function automatic logic [WIDTH-1:0] dec_sat(input logic [WIDTH-1:0] v);
    if (v == '0) return '0;
    return v - WIDTH'(1);
  endfunction

  // >= rather than == so that lowering prescale mid-count ticks on the next
  // edge instead of letting the prescaler run all the way round.
  assign tick     = (presc >= prescale);
  assign terminal = tick && (count == WIDTH'(1));

  // State register
  always_ff @(posedge c or posedge r) begin
    if (r) state <= IDLE;
    else   state <= state_nx;
  end

  // Counter, prescaler and pulse registers
  always_ff @(posedge c or posedge r) begin
    if (r) begin
      count   <= '0;
      presc   <= '0;
      expired <= 1'b0;
    end else begin
      count   <= count_nx;
      presc   <= presc_nx;
      expired <= expired_nx;
    end
  end

  // Next-state logic; priority is s > terminal tick > e > p.
  always_comb begin
    state_nx   = state;
    count_nx   = count;
    presc_nx   = presc;
    expired_nx = 1'b0;
    if (s) begin
      // Stop keeps count for readout and suppresses any pending expiry.
      state_nx = IDLE;
      presc_nx = '0;
    end else begin
      case (state)
        IDLE, EXPIRED: begin
          if (e) begin
            count_nx = load_val;
            presc_nx = '0;
            if (load_val == '0) begin
              state_nx   = EXPIRED;
              expired_nx = 1'b1;
            end else begin
              state_nx = RUN;
            end
          end
        end
        RUN: begin
          if (terminal) begin
            expired_nx = 1'b1;
            presc_nx   = '0;
            if (reload_en && (load_val != '0)) begin
              count_nx = load_val;
            end else begin
              count_nx = '0;
              state_nx = EXPIRED;
            end
          end else if (p) begin
            // The pause edge neither ticks nor advances the prescaler.
            state_nx = PAUSE;
          end else if (tick) begin
            count_nx = dec_sat(count);
            presc_nx = '0;
          end else begin
            presc_nx = presc + PRESCALE_W'(1);
          end
        end
        PAUSE: begin
          if (e) state_nx = RUN;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    currentState = state;
    busy         = (state == RUN) || (state == PAUSE);
  end

endmodule

// File: tb/tb_timer_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_timer_ctrl_fsm
//   Self-checking bench for timer_ctrl_fsm (WIDTH=16, PRESCALE_W=8).
//   Table of per-edge vectors plus hand-written prescaler, pause/resume and
//   asynchronous-reset sequences.
// -----------------------------------------------------------------------------
module tb_timer_ctrl_fsm;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_PAU  = 2'b10;
  localparam logic [1:0] S_EXP  = 2'b11;

  logic        c = 1'b0;
  logic        r = 1'b0;
  logic        e = 1'b0;
  logic        s = 1'b0;
  logic        p = 1'b0;
  logic        reload_en = 1'b0;
  logic [15:0] load_val = '0;
  logic [7:0]  prescale = '0;
  logic [15:0] count;
  logic [1:0]  currentState;
  logic        expired;
  logic        busy;

  int checks = 0;
  int errors = 0;

  timer_ctrl_fsm #(.WIDTH(16), .PRESCALE_W(8)) dut (
    .c(c), .r(r), .e(e), .s(s), .p(p),
    .reload_en(reload_en), .load_val(load_val), .prescale(prescale),
    .count(count), .currentState(currentState),
    .expired(expired), .busy(busy)
  );

  always #5 c = ~c;

  typedef struct {
    logic        e, s, p, rl;
    logic [15:0] lv;
    logic [7:0]  ps;
    logic [15:0] cnt;
    logic [1:0]  st;
    logic        ex;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic ve, vs, vp, vrl,
                              input logic [15:0] vlv, input logic [7:0] vps,
                              input logic [15:0] vcnt, input logic [1:0] vst,
                              input logic vex);
    vec_t v;
    v.e = ve; v.s = vs; v.p = vp; v.rl = vrl;
    v.lv = vlv; v.ps = vps;
    v.cnt = vcnt; v.st = vst; v.ex = vex;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [15:0] cnt, input logic [1:0] st,
                     input logic ex);
    logic bs;
    bs = (st == S_RUN) || (st == S_PAU);
    checks++;
    if ({count, currentState, expired, busy} !== {cnt, st, ex, bs}) begin
      errors++;
      $display("FAIL %s[%0d]: got count=%0d state=%b expired=%b busy=%b, want count=%0d state=%b expired=%b busy=%b",
               name, idx, count, currentState, expired, busy, cnt, st, ex, bs);
    end
  endtask

  task automatic drive(input logic ve, vs, vp, vrl,
                       input logic [15:0] vlv, input logic [7:0] vps);
    e = ve; s = vs; p = vp; reload_en = vrl; load_val = vlv; prescale = vps;
  endtask

  task automatic step();
    @(posedge c);
    #1;
  endtask

  initial begin
    //   e  s  p  rl  lv       ps    cnt      st      ex
    // Basic one-shot countdown 3,2,1,0
    add(1, 0, 0, 0, 16'd3,   8'd0, 16'd3,   S_RUN,  0);
    add(0, 0, 0, 0, 16'd3,   8'd0, 16'd2,   S_RUN,  0);
    add(0, 0, 0, 0, 16'd3,   8'd0, 16'd1,   S_RUN,  0);
    add(0, 0, 0, 0, 16'd3,   8'd0, 16'd0,   S_EXP,  1);
    add(0, 0, 0, 0, 16'd3,   8'd0, 16'd0,   S_EXP,  0);
    add(0, 0, 1, 0, 16'd3,   8'd0, 16'd0,   S_EXP,  0);
    add(0, 1, 0, 0, 16'd3,   8'd0, 16'd0,   S_IDLE, 0);
    // Auto-reload 2,1,2,1 with pulses; e ignored while running
    add(1, 0, 0, 1, 16'd2,   8'd0, 16'd2,   S_RUN,  0);
    add(0, 0, 0, 1, 16'd2,   8'd0, 16'd1,   S_RUN,  0);
    add(0, 0, 0, 1, 16'd2,   8'd0, 16'd2,   S_RUN,  1);
    add(0, 0, 0, 1, 16'd2,   8'd0, 16'd1,   S_RUN,  0);
    add(0, 0, 0, 1, 16'd2,   8'd0, 16'd2,   S_RUN,  1);
    add(1, 0, 0, 1, 16'd2,   8'd0, 16'd1,   S_RUN,  0);
    // Stop on the terminal-tick edge: no pulse, count holds 1
    add(0, 1, 0, 1, 16'd2,   8'd0, 16'd1,   S_IDLE, 0);
    // Pause beats a non-terminal tick; terminal tick beats pause
    add(1, 0, 0, 0, 16'd2,   8'd0, 16'd2,   S_RUN,  0);
    add(0, 0, 1, 0, 16'd2,   8'd0, 16'd2,   S_PAU,  0);
    add(0, 0, 1, 0, 16'd2,   8'd0, 16'd2,   S_PAU,  0);
    add(1, 0, 0, 0, 16'd2,   8'd0, 16'd2,   S_RUN,  0);
    add(0, 0, 0, 0, 16'd2,   8'd0, 16'd1,   S_RUN,  0);
    add(0, 0, 1, 0, 16'd2,   8'd0, 16'd0,   S_EXP,  1);
    // Zero load from IDLE and from EXPIRED
    add(1, 0, 0, 0, 16'd0,   8'd0, 16'd0,   S_EXP,  1);
    add(0, 0, 0, 0, 16'd0,   8'd0, 16'd0,   S_EXP,  0);
    add(1, 0, 0, 0, 16'd0,   8'd0, 16'd0,   S_EXP,  1);
    add(0, 1, 0, 0, 16'd0,   8'd0, 16'd0,   S_IDLE, 0);
    add(0, 0, 1, 0, 16'd0,   8'd0, 16'd0,   S_IDLE, 0);
    add(1, 0, 0, 0, 16'd0,   8'd0, 16'd0,   S_EXP,  1);
    add(0, 1, 0, 0, 16'd0,   8'd0, 16'd0,   S_IDLE, 0);
    // Reload of 1, then reload value switched to 0 -> expire once
    add(1, 0, 0, 1, 16'd1,   8'd0, 16'd1,   S_RUN,  0);
    add(0, 0, 0, 1, 16'd1,   8'd0, 16'd1,   S_RUN,  1);
    add(0, 0, 0, 1, 16'd0,   8'd0, 16'd0,   S_EXP,  1);
    add(0, 0, 0, 1, 16'd0,   8'd0, 16'd0,   S_EXP,  0);
    add(0, 1, 0, 0, 16'd0,   8'd0, 16'd0,   S_IDLE, 0);
    // All-ones load
    add(1, 0, 0, 0, 16'hFFFF, 8'd0, 16'hFFFF, S_RUN, 0);
    add(0, 0, 0, 0, 16'hFFFF, 8'd0, 16'hFFFE, S_RUN, 0);
    add(0, 1, 0, 0, 16'hFFFF, 8'd0, 16'hFFFE, S_IDLE, 0);

    // Reset
    #2 r = 1'b1;
    #1 chk("reset_async", 0, 16'd0, S_IDLE, 1'b0);
    step();
    step();
    r = 1'b0;
    step();
    chk("reset_release", 0, 16'd0, S_IDLE, 1'b0);

    // Table
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].e, vecs[i].s, vecs[i].p, vecs[i].rl, vecs[i].lv, vecs[i].ps);
      step();
      chk("table", i, vecs[i].cnt, vecs[i].st, vecs[i].ex);
    end

    // Prescaler: load 2, prescale 3 -> decrement every 4 edges, expire at 8
    drive(1, 0, 0, 0, 16'd2, 8'd3);
    step();
    chk("presc_load", 0, 16'd2, S_RUN, 1'b0);
    drive(0, 0, 0, 0, 16'd2, 8'd3);
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k < 4)       chk("presc", k, 16'd2, S_RUN, 1'b0);
      else if (k < 8)  chk("presc", k, 16'd1, S_RUN, 1'b0);
      else             chk("presc", k, 16'd0, S_EXP, 1'b1);
    end
    drive(0, 1, 0, 0, 16'd2, 8'd0);
    step();
    chk("presc_stop", 0, 16'd0, S_IDLE, 1'b0);

    // Pause/resume: load 10, pause at 6 for 5 cycles, then 5,4,3
    drive(1, 0, 0, 0, 16'd10, 8'd0);
    step();
    chk("pause_load", 0, 16'd10, S_RUN, 1'b0);
    drive(0, 0, 0, 0, 16'd10, 8'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("pause_run", k, 16'(10 - k), S_RUN, 1'b0);
    end
    drive(0, 0, 1, 0, 16'd10, 8'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("pause_hold", k, 16'd6, S_PAU, 1'b0);
    end
    drive(1, 0, 0, 0, 16'd10, 8'd0);
    step();
    chk("pause_resume", 0, 16'd6, S_RUN, 1'b0);
    drive(0, 0, 0, 0, 16'd10, 8'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("pause_after", k, 16'(6 - k), S_RUN, 1'b0);
    end
    drive(0, 1, 0, 0, 16'd10, 8'd0);
    step();
    chk("pause_stop", 0, 16'd3, S_IDLE, 1'b0);

    // Asynchronous reset between edges at count 5
    drive(1, 0, 0, 0, 16'd10, 8'd0);
    step();
    drive(0, 0, 0, 0, 16'd10, 8'd0);
    for (int k = 0; k < 5; k++) step();
    chk("arst_pre", 0, 16'd5, S_RUN, 1'b0);
    #2 r = 1'b1;
    #1 chk("arst_now", 0, 16'd0, S_IDLE, 1'b0);
    step();
    chk("arst_held", 0, 16'd0, S_IDLE, 1'b0);
    r = 1'b0;
    step();
    chk("arst_after", 0, 16'd0, S_IDLE, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
